// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and constants for the PLL lock supervisor.
// Holds the FSM state encoding and the lock-loss counter limits.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RELEASE,
        ST_RUN,
        ST_FAULT
    } pll_sup_state_t;

    localparam int unsigned LOSS_CNT_W = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

    function automatic logic [LOSS_CNT_W-1:0] loss_cnt_inc(input logic [LOSS_CNT_W-1:0] v);
        return (v == LOSS_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-side and clock-consumer-side signals of the lock supervisor.
// The slave modport is the supervisor; the master modport is the environment.
interface pll_lock_supervisor_if #(
    parameter int unsigned NUM_CLKS    = 3,
    parameter int unsigned MAX_RETRIES = 3
);
    import pll_sup_pkg::*;

    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    logic                  pll_locked;
    logic                  relock_req;
    logic                  pll_rst;
    logic [NUM_CLKS-1:0]   chan_rst_n;
    logic                  ready;
    logic                  fault;
    logic [RETRY_W-1:0]    retry_cnt;
    logic [LOSS_CNT_W-1:0] lock_loss_cnt;

    modport master (
        output pll_locked, relock_req,
        input  pll_rst, chan_rst_n, ready, fault, retry_cnt, lock_loss_cnt
    );

    modport slave (
        input  pll_locked, relock_req,
        output pll_rst, chan_rst_n, ready, fault, retry_cnt, lock_loss_cnt
    );

endinterface

// File: rtl/pll_lock_supervisor_sync.sv
// Two-flop synchroniser with asynchronous active-low reset.
module pll_sup_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock/reset supervisor: resets the PLL, qualifies lock, staggers channel resets.
// Define PLL_SUP_LOSS_CNT_EN to implement the saturating lock-loss counter.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned NUM_CLKS         = 3,
    parameter int unsigned PLL_RST_CYC      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned STAGGER_CYC      = 8,
    parameter int unsigned MAX_RETRIES      = 3
) (
    input logic                  refclk,
    input logic                  rst_n,
    pll_lock_supervisor_if.slave bus
);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int unsigned RST_W   = $clog2(PLL_RST_CYC + 1);
    localparam int unsigned TO_W    = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int unsigned STB_W   = $clog2(LOCK_STABLE_CYC + 1);
    localparam int unsigned STG_W   = $clog2(STAGGER_CYC + 1);
    localparam int unsigned IDX_W   = $clog2(NUM_CLKS + 1);

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(PLL_RST_CYC - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [STB_W-1:0]   STB_LAST  = STB_W'(LOCK_STABLE_CYC - 1);
    localparam logic [STG_W-1:0]   STG_LAST  = STG_W'(STAGGER_CYC - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_CLKS - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic w_lock_s;

    pll_sup_state_t      r_state,      w_state_nxt;
    logic [RST_W-1:0]    r_rst_cnt,    w_rst_cnt_nxt;
    logic [TO_W-1:0]     r_to_cnt,     w_to_cnt_nxt;
    logic [STB_W-1:0]    r_stb_cnt,    w_stb_cnt_nxt;
    logic [STG_W-1:0]    r_stg_cnt,    w_stg_cnt_nxt;
    logic [IDX_W-1:0]    r_idx,        w_idx_nxt;
    logic                r_pll_rst,    w_pll_rst_nxt;
    logic [NUM_CLKS-1:0] r_chan_rst_n, w_chan_rst_n_nxt;
    logic                r_ready,      w_ready_nxt;
    logic                r_fault,      w_fault_nxt;
    logic [RETRY_W-1:0]  r_retry_cnt,  w_retry_cnt_nxt;
    logic                w_drop;

    pll_sup_sync u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .i_d   (bus.pll_locked),
        .o_q   (w_lock_s)
    );

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_PLL_RST;
            r_rst_cnt    <= '0;
            r_to_cnt     <= '0;
            r_stb_cnt    <= '0;
            r_stg_cnt    <= '0;
            r_idx        <= '0;
            r_pll_rst    <= 1'b1;
            r_chan_rst_n <= '0;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
            r_retry_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rst_cnt    <= w_rst_cnt_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            r_stb_cnt    <= w_stb_cnt_nxt;
            r_stg_cnt    <= w_stg_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_pll_rst    <= w_pll_rst_nxt;
            r_chan_rst_n <= w_chan_rst_n_nxt;
            r_ready      <= w_ready_nxt;
            r_fault      <= w_fault_nxt;
            r_retry_cnt  <= w_retry_cnt_nxt;
        end
    end

    // Output registers are computed one cycle ahead so every output leaves a flop directly.
    always_comb begin
        w_state_nxt      = r_state;
        w_rst_cnt_nxt    = '0;
        w_to_cnt_nxt     = '0;
        w_stb_cnt_nxt    = '0;
        w_stg_cnt_nxt    = '0;
        w_idx_nxt        = r_idx;
        w_pll_rst_nxt    = r_pll_rst;
        w_chan_rst_n_nxt = r_chan_rst_n;
        w_ready_nxt      = r_ready;
        w_fault_nxt      = r_fault;
        w_retry_cnt_nxt  = r_retry_cnt;
        w_drop           = 1'b0;

        unique case (r_state)
            ST_PLL_RST: begin
                if (r_rst_cnt == RST_LAST) begin
                    w_state_nxt   = ST_WAIT_LOCK;
                    w_pll_rst_nxt = 1'b0;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (bus.relock_req) begin
                    w_drop = 1'b1;
                end else if (w_lock_s) begin
                    w_state_nxt = ST_STABLE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_retry_cnt_nxt = r_retry_cnt + 1'b1;
                    w_pll_rst_nxt   = 1'b1;
                    if (w_retry_cnt_nxt == RETRY_MAX) begin
                        w_state_nxt = ST_FAULT;
                        w_fault_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_PLL_RST;
                    end
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
            end
            ST_STABLE: begin
                if (bus.relock_req) begin
                    w_drop = 1'b1;
                end else if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_stb_cnt == STB_LAST) begin
                    w_chan_rst_n_nxt[0] = 1'b1;
                    w_idx_nxt           = IDX_W'(1);
                    if (NUM_CLKS == 1) begin
                        w_state_nxt     = ST_RUN;
                        w_ready_nxt     = 1'b1;
                        w_retry_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                    end
                end else begin
                    w_stb_cnt_nxt = r_stb_cnt + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (bus.relock_req || !w_lock_s) begin
                    w_drop = 1'b1;
                end else if (r_stg_cnt == STG_LAST) begin
                    for (int unsigned i = 0; i < NUM_CLKS; i++) begin
                        if (r_idx == IDX_W'(i)) w_chan_rst_n_nxt[i] = 1'b1;
                    end
                    w_idx_nxt = r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt     = ST_RUN;
                        w_ready_nxt     = 1'b1;
                        w_retry_cnt_nxt = '0;
                    end
                end else begin
                    w_stg_cnt_nxt = r_stg_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.relock_req || !w_lock_s) w_drop = 1'b1;
            end
            ST_FAULT: begin
                if (bus.relock_req) begin
                    w_state_nxt     = ST_PLL_RST;
                    w_fault_nxt     = 1'b0;
                    w_retry_cnt_nxt = '0;
                end
            end
            default: w_drop = 1'b1;
        endcase

        if (w_drop) begin
            w_state_nxt      = ST_PLL_RST;
            w_pll_rst_nxt    = 1'b1;
            w_chan_rst_n_nxt = '0;
            w_ready_nxt      = 1'b0;
        end
    end

`ifdef PLL_SUP_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] r_loss_cnt;
    logic                  w_loss_evt;

    // A simultaneous relock request in RUN still counts as exactly one loss.
    assign w_loss_evt = (r_state == ST_RUN) && !w_lock_s;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss_evt) begin
            r_loss_cnt <= loss_cnt_inc(r_loss_cnt);
        end
    end

    assign bus.lock_loss_cnt = r_loss_cnt;
`else
    assign bus.lock_loss_cnt = '0;
`endif

    assign bus.pll_rst    = r_pll_rst;
    assign bus.chan_rst_n = r_chan_rst_n;
    assign bus.ready      = r_ready;
    assign bus.fault      = r_fault;
    assign bus.retry_cnt  = r_retry_cnt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor; channel release events are scoreboarded.
// Honors PLL_SUP_LOSS_CNT_EN for the expected lock-loss count.
module tb_pll_lock_supervisor;
    import pll_sup_pkg::*;

    localparam int NC  = 3;
    localparam int PRC = 4;
    localparam int LTC = 32;
    localparam int LSC = 4;
    localparam int STG = 2;
    localparam int MR  = 3;
`ifdef PLL_SUP_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;
    int   cyc    = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct {
        logic [NC-1:0] chan;
        logic          rdy;
        int            cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    pll_lock_supervisor_if #(.NUM_CLKS(NC), .MAX_RETRIES(MR)) bus ();

    pll_lock_supervisor #(
        .NUM_CLKS         (NC),
        .PLL_RST_CYC      (PRC),
        .LOCK_TIMEOUT_CYC (LTC),
        .LOCK_STABLE_CYC  (LSC),
        .STAGGER_CYC      (STG),
        .MAX_RETRIES      (MR)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic apply_reset(output int rel_cyc);
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        tick(3);
        rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    // Expected release events for a lock rise driven just after edge r.
    task automatic push_bringup(input int r);
        ev_t e;
        logic [NC-1:0] p;
        int t;
        p = '0;
        t = r + 3 + LSC - 1;
        for (int i = 0; i < NC; i++) begin
            p[i]  = 1'b1;
            e.chan = p;
            e.rdy  = (i == NC - 1);
            e.cyc  = t + 1 + i * STG;
            exp_q.push_back(e);
        end
    endtask

    task automatic collect(input int n);
        logic [NC-1:0] last;
        ev_t o;
        last = bus.chan_rst_n;
        repeat (n) begin
            tick();
            if (bus.chan_rst_n !== last) begin
                o.chan = bus.chan_rst_n;
                o.rdy  = bus.ready;
                o.cyc  = cyc;
                obs_q.push_back(o);
                last = bus.chan_rst_n;
            end
        end
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        int w;
        w = 0;
        while (bus.ready !== 1'b1 && w < budget) begin
            tick();
            w++;
        end
        ok = (bus.ready === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        tick(2);
        n_tests++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst: got %b, expected 1", bus.pll_rst); end
        n_tests++; if (bus.chan_rst_n !== '0) begin n_fail++; $display("FAIL reset_chan: got %b, expected 000", bus.chan_rst_n); end
        n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, expected 0", bus.ready); end
        n_tests++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b, expected 0", bus.fault); end
        n_tests++; if (bus.retry_cnt !== '0) begin n_fail++; $display("FAIL reset_retry: got %0d, expected 0", bus.retry_cnt); end
        n_tests++; if (bus.lock_loss_cnt !== '0) begin n_fail++; $display("FAIL reset_loss: got %0d, expected 0", bus.lock_loss_cnt); end
    endtask

    task automatic test_nominal();
        int c0, r;
        ev_t e, o;
        apply_reset(c0);
        tick(PRC - 1);
        n_tests++; if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL nominal_pll_rst_hold: got %b, expected 1", bus.pll_rst); end
        tick(1);
        n_tests++; if (bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL nominal_pll_rst_drop: got %b, expected 0", bus.pll_rst); end
        tick_to(c0 + 10);
        r = cyc;
        bus.pll_locked = 1'b1;
        push_bringup(r);
        collect(16);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL nominal_release: no event, expected chan=%b ready=%b at cycle %0d", e.chan, e.rdy, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.chan !== e.chan || o.rdy !== e.rdy || o.cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL nominal_release: got chan=%b ready=%b cycle=%0d, expected chan=%b ready=%b cycle=%0d",
                             o.chan, o.rdy, o.cyc, e.chan, e.rdy, e.cyc);
                end
            end
        end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL nominal_extra: got %0d extra changes, expected 0", obs_q.size()); end
        obs_q.delete();
        n_tests++; if (bus.ready !== 1'b1 || bus.retry_cnt !== '0) begin n_fail++; $display("FAIL nominal_run: got ready=%b retry=%0d, expected ready=1 retry=0", bus.ready, bus.retry_cnt); end
    endtask

    task automatic test_glitch();
        int c0, f;
        ev_t e, o;
        apply_reset(c0);
        tick(10);
        bus.pll_locked = 1'b1;
        tick(2);
        bus.pll_locked = 1'b0;
        tick(1);
        bus.pll_locked = 1'b1;
        f = cyc;
        push_bringup(f);
        collect(16);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL glitch_release: no event, expected chan=%b at cycle %0d", e.chan, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.chan !== e.chan || o.rdy !== e.rdy || o.cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL glitch_release: got chan=%b ready=%b cycle=%0d, expected chan=%b ready=%b cycle=%0d",
                             o.chan, o.rdy, o.cyc, e.chan, e.rdy, e.cyc);
                end
            end
        end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_extra: got %0d extra changes, expected 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_timeout();
        int c0, x, att;
        bit ok;
        att = PRC + LTC;
        apply_reset(c0);
        tick_to(c0 + PRC);
        n_tests++; if (bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL timeout_wait_pll_rst: got %b, expected 0", bus.pll_rst); end
        tick_to(c0 + att - 1);
        n_tests++; if (bus.retry_cnt !== 2'd0 || bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL timeout_pre1: got retry=%0d pll_rst=%b, expected 0/0", bus.retry_cnt, bus.pll_rst); end
        tick_to(c0 + att);
        n_tests++; if (bus.retry_cnt !== 2'd1 || bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL timeout_1: got retry=%0d pll_rst=%b, expected 1/1", bus.retry_cnt, bus.pll_rst); end
        tick_to(c0 + 2 * att);
        n_tests++; if (bus.retry_cnt !== 2'd2 || bus.fault !== 1'b0) begin n_fail++; $display("FAIL timeout_2: got retry=%0d fault=%b, expected 2/0", bus.retry_cnt, bus.fault); end
        tick_to(c0 + 3 * att - 1);
        n_tests++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL timeout_prefault: got fault=%b, expected 0", bus.fault); end
        tick_to(c0 + 3 * att);
        n_tests++;
        if (bus.fault !== 1'b1 || bus.retry_cnt !== 2'd3 || bus.pll_rst !== 1'b1 || bus.chan_rst_n !== '0) begin
            n_fail++;
            $display("FAIL timeout_fault: got fault=%b retry=%0d pll_rst=%b chan=%b, expected 1/3/1/000",
                     bus.fault, bus.retry_cnt, bus.pll_rst, bus.chan_rst_n);
        end
        tick(20);
        n_tests++; if (bus.fault !== 1'b1 || bus.retry_cnt !== 2'd3 || bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL timeout_hold: got fault=%b retry=%0d pll_rst=%b, expected 1/3/1", bus.fault, bus.retry_cnt, bus.pll_rst); end
        bus.relock_req = 1'b1;
        x = cyc;
        tick();
        bus.relock_req = 1'b0;
        n_tests++; if (bus.fault !== 1'b0 || bus.retry_cnt !== 2'd0 || bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL timeout_relock: got fault=%b retry=%0d pll_rst=%b, expected 0/0/1", bus.fault, bus.retry_cnt, bus.pll_rst); end
        bus.pll_locked = 1'b1;
        wait_ready(40, ok);
        n_tests++; if (!ok || cyc != x + 1 + PRC + 1 + LSC + (NC - 1) * STG) begin n_fail++; $display("FAIL timeout_restart: got ready=%b at cycle %0d, expected ready=1 at cycle %0d", bus.ready, cyc, x + 1 + PRC + 1 + LSC + (NC - 1) * STG); end
    endtask

    task automatic test_loss_repeat();
        int c0, d, exp_loss;
        bit ok;
        apply_reset(c0);
        tick(10);
        bus.pll_locked = 1'b1;
        wait_ready(30, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL loss_initial_ready: got ready=%b, expected 1", bus.ready); end
        exp_loss = 0;
        for (int k = 0; k < 300; k++) begin
            bus.pll_locked = 1'b0;
            d = cyc;
            tick_to(d + 3);
            if (LOSS_EN && exp_loss < 255) exp_loss++;
            n_tests++;
            if (bus.chan_rst_n !== '0 || bus.ready !== 1'b0 || bus.pll_rst !== 1'b1) begin
                n_fail++;
                $display("FAIL loss_reset[%0d]: got chan=%b ready=%b pll_rst=%b, expected 000/0/1", k, bus.chan_rst_n, bus.ready, bus.pll_rst);
            end
            n_tests++;
            if (bus.lock_loss_cnt !== 8'(exp_loss)) begin
                n_fail++;
                $display("FAIL loss_count[%0d]: got %0d, expected %0d", k, bus.lock_loss_cnt, exp_loss);
            end
            bus.pll_locked = 1'b1;
            wait_ready(40, ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL loss_reacquire[%0d]: got ready=%b, expected 1", k, bus.ready);
                break;
            end
        end
        n_tests++; if (bus.lock_loss_cnt !== (LOSS_EN ? 8'd255 : 8'd0)) begin n_fail++; $display("FAIL loss_saturate: got %0d, expected %0d", bus.lock_loss_cnt, LOSS_EN ? 255 : 0); end
    endtask

    task automatic test_simul();
        int c0, d, hi;
        bit ok;
        apply_reset(c0);
        tick(10);
        bus.pll_locked = 1'b1;
        wait_ready(30, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL simul_ready: got ready=%b, expected 1", bus.ready); end
        // relock_req is timed to meet the synchronised lock drop at the FSM.
        bus.pll_locked = 1'b0;
        d = cyc;
        tick_to(d + 2);
        bus.relock_req = 1'b1;
        tick();
        bus.relock_req = 1'b0;
        n_tests++; if (bus.lock_loss_cnt !== (LOSS_EN ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL simul_count: got %0d, expected %0d", bus.lock_loss_cnt, LOSS_EN ? 1 : 0); end
        n_tests++; if (bus.chan_rst_n !== '0 || bus.ready !== 1'b0) begin n_fail++; $display("FAIL simul_reset: got chan=%b ready=%b, expected 000/0", bus.chan_rst_n, bus.ready); end
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.pll_rst === 1'b1) hi++;
            tick();
        end
        n_tests++; if (hi != PRC) begin n_fail++; $display("FAIL simul_single_entry: got pll_rst high %0d cycles, expected %0d", hi, PRC); end
    endtask

    task automatic test_rst_mid();
        int c0, r;
        ev_t e, o;
        apply_reset(c0);
        tick(10);
        r = cyc;
        bus.pll_locked = 1'b1;
        tick_to(r + 3 + LSC);
        n_tests++; if (bus.chan_rst_n !== 3'b001) begin n_fail++; $display("FAIL rstmid_chan0: got %b, expected 001", bus.chan_rst_n); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.pll_rst !== 1'b1 || bus.chan_rst_n !== '0 || bus.ready !== 1'b0 || bus.fault !== 1'b0 ||
            bus.retry_cnt !== '0 || bus.lock_loss_cnt !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: got pll_rst=%b chan=%b ready=%b fault=%b retry=%0d loss=%0d, expected 1/000/0/0/0/0",
                     bus.pll_rst, bus.chan_rst_n, bus.ready, bus.fault, bus.retry_cnt, bus.lock_loss_cnt);
        end
        apply_reset(c0);
        tick(10);
        r = cyc;
        bus.pll_locked = 1'b1;
        push_bringup(r);
        collect(16);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL rstmid_release: no event, expected chan=%b at cycle %0d", e.chan, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.chan !== e.chan || o.rdy !== e.rdy || o.cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL rstmid_release: got chan=%b ready=%b cycle=%0d, expected chan=%b ready=%b cycle=%0d",
                             o.chan, o.rdy, o.cyc, e.chan, e.rdy, e.cyc);
                end
            end
        end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rstmid_extra: got %0d extra changes, expected 0", obs_q.size()); end
        obs_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        test_reset();
        test_nominal();
        test_glitch();
        test_timeout();
        test_loss_repeat();
        test_simul();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
